// File: rtl/fft_pkg.sv
// Shared types, constants and helper functions for the FFT sequencer and datapath.
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_DRAIN,
        ST_UNLOAD,
        ST_FLUSH,
        ST_DONE
    } fft_state_t;

    // Fixed-point widths shared by butterfly, twiddle ROM and sample RAM.
    localparam int data_w  = 16;
    localparam int twid_w  = 16;
    localparam int guard_w = 2;
    localparam int acc_w   = data_w + guard_w;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Reverse the low 'width' bits of value; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        v = value;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = {r[30:0], v[0]};
                v = {1'b0, v[31:1]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear of every stage.
module fft_delay_line #(
    parameter int width = 1,
    parameter int depth = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] pipe [depth];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < depth; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[depth-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: bit-reversed load, stage-by-stage
// butterfly issue with writeback drain, then natural-order unload.
//
// state  | meaning
// IDLE   | waiting for start_data
// LOAD   | accepting no_point samples into bit-reversed addresses
// CALC   | issuing one butterfly per cycle for stage s
// DRAIN  | waiting bf_lat cycles for the stage's writebacks to land
// UNLOAD | issuing natural-order reads, one per cycle
// FLUSH  | waiting rd_lat cycles for the last read data
// DONE   | one-cycle completion pulse
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int  no_point = 8,
    parameter int  bf_lat   = 3,
    parameter int  rd_lat   = 1,
    localparam int aw       = clog2(no_point)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_data,
    input  logic          inverse,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ld_en,
    output logic [aw-1:0] ld_addr,
    output logic          bf_issue,
    output logic [aw-1:0] bf_addr_a,
    output logic [aw-1:0] bf_addr_b,
    output logic [aw-2:0] tw_idx,
    output logic          tw_conj,
    output logic          wb_en,
    output logic [aw-1:0] wb_addr_a,
    output logic [aw-1:0] wb_addr_b,
    output logic          rd_en,
    output logic [aw-1:0] rd_addr,
    output logic          out_valid,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int tmr_max = (bf_lat > rd_lat) ? bf_lat : rd_lat;
    localparam int tmr_w   = clog2(tmr_max + 1);

    fft_state_t       state, state_nxt;
    logic [aw-1:0]    k, s, b, rd_cnt;
    logic [tmr_w-1:0] timer;

    logic             k_last, b_last, s_last, rd_last, tmr_zero;
    logic [aw-1:0]    half, pos, grp, addr_a;
    logic [aw-2:0]    tw_pos;

    assign k_last   = (k == aw'(no_point - 1));
    assign b_last   = (b == aw'(no_point / 2 - 1));
    assign s_last   = (s == aw'(aw - 1));
    assign rd_last  = (rd_cnt == aw'(no_point - 1));
    assign tmr_zero = (timer == '0);

    // Butterfly b of stage s pairs addr_a with addr_a + 2^s inside group b >> s.
    always_comb begin
        half   = aw'(1) << s;
        pos    = b & (half - aw'(1));
        grp    = b >> s;
        addr_a = (grp << (s + aw'(1))) | pos;
        tw_pos = pos[aw-2:0] << (aw'(aw - 1) - s);
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        bf_issue  = 1'b0;
        bf_addr_a = '0;
        bf_addr_b = '0;
        tw_idx    = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_data) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                ld_en    = in_valid;
                ld_addr  = aw'(bitrev(32'(k), aw));
                if (in_valid && k_last) state_nxt = ST_CALC;
            end
            ST_CALC: begin
                bf_issue  = 1'b1;
                bf_addr_a = addr_a;
                bf_addr_b = addr_a | half;
                tw_idx    = tw_pos;
                if (b_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tmr_zero) state_nxt = s_last ? ST_UNLOAD : ST_CALC;
            end
            ST_UNLOAD: begin
                rd_en   = 1'b1;
                rd_addr = rd_cnt;
                if (rd_last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (tmr_zero) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Wait phases share one down-counter, loaded on the last cycle of the preceding phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k       <= '0;
            s       <= '0;
            b       <= '0;
            rd_cnt  <= '0;
            timer   <= '0;
            tw_conj <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_data) begin
                        tw_conj <= inverse;
                        k       <= '0;
                        s       <= '0;
                        b       <= '0;
                        rd_cnt  <= '0;
                        timer   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) k <= k_last ? '0 : k + aw'(1);
                end
                ST_CALC: begin
                    if (b_last) begin
                        b     <= '0;
                        timer <= tmr_w'(bf_lat - 1);
                    end else begin
                        b <= b + aw'(1);
                    end
                end
                ST_DRAIN: begin
                    if (tmr_zero) begin
                        if (!s_last) s <= s + aw'(1);
                    end else begin
                        timer <= timer - tmr_w'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (rd_last) begin
                        rd_cnt <= '0;
                        timer  <= tmr_w'(rd_lat - 1);
                    end else begin
                        rd_cnt <= rd_cnt + aw'(1);
                    end
                end
                ST_FLUSH: begin
                    if (!tmr_zero) timer <= timer - tmr_w'(1);
                end
                default: ;
            endcase
        end
    end

    fft_delay_line #(
        .width (2 * aw + 1),
        .depth (bf_lat)
    ) u_wb_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  ({bf_issue, bf_addr_a, bf_addr_b}),
        .dout ({wb_en, wb_addr_a, wb_addr_b})
    );

    fft_delay_line #(
        .width (2),
        .depth (rd_lat)
    ) u_rd_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en, rd_en & rd_last}),
        .dout ({out_valid, out_last})
    );

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Randomized directed bench for fft_seq_ctrl against a cycle-level reference
// derived from the FFT addressing and phase-length rules.
module tb_fft_seq_ctrl;

    localparam int N     = 8;
    localparam int BL    = 3;
    localparam int RL    = 1;
    localparam int AW    = $clog2(N);
    localparam int NB    = AW * N / 2;
    localparam int TOTAL = AW * (N / 2 + BL) + N + RL + 1;

    typedef struct {
        int due;
        int a;
        int b;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst, start_data, inverse, in_valid;
    logic          in_ready, ld_en, bf_issue, tw_conj, wb_en, rd_en;
    logic          out_valid, out_last, busy, done;
    logic [AW-1:0] ld_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, rd_addr;
    logic [AW-2:0] tw_idx;
    logic [63:0]   all_out;

    int vectors     = 0;
    int miscompares = 0;
    int ref_a  [NB];
    int ref_b  [NB];
    int ref_tw [NB];

    always #5 clk = ~clk;

    fft_seq_ctrl #(.no_point(N), .bf_lat(BL), .rd_lat(RL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_data (start_data),
        .inverse    (inverse),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .bf_issue   (bf_issue),
        .bf_addr_a  (bf_addr_a),
        .bf_addr_b  (bf_addr_b),
        .tw_idx     (tw_idx),
        .tw_conj    (tw_conj),
        .wb_en      (wb_en),
        .wb_addr_a  (wb_addr_a),
        .wb_addr_b  (wb_addr_b),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    assign all_out = 64'({in_ready, ld_en, ld_addr, bf_issue, bf_addr_a, bf_addr_b, tw_idx,
                          tw_conj, wb_en, wb_addr_a, wb_addr_b, rd_en, rd_addr,
                          out_valid, out_last, busy, done});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < AW; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic run_fft(input bit inv, input bit gaps, input bit noise, input bit rst_mid);
        int  n_loaded = 0, issue_idx = 0, cyc = 0;
        int  last_load = -1, last_issue = -1, us = -1;
        bit  loading = 1'b1, fin = 1'b0, aborted = 1'b0;
        bit  exp_wb, exp_rd, exp_done;
        wb_t wbq[$];
        wb_t w;

        // IDLE: in_valid must be ignored
        in_valid = 1'b1; start_data = 1'b0; inverse = 1'b0;
        @(negedge clk);
        chk("idle_ld_en", ld_en, 0);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;

        start_data = 1'b1; inverse = inv; in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("start_ld_en", ld_en, 0);
        chk("start_busy", busy, 0);
        @(posedge clk); #1;
        start_data = 1'b0;
        inverse    = 1'($urandom_range(0, 1));

        for (int t = 0; t < 1000; t++) begin
            if (loading) in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            else         in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            start_data = (!loading && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) inverse = 1'($urandom_range(0, 1));
            @(negedge clk);

            chk("busy", busy, 1);
            chk("tw_conj", tw_conj, inv);
            chk("in_ready", in_ready, loading);
            chk("ld_en", ld_en, loading && in_valid);
            if (loading && in_valid) begin
                chk("ld_addr", ld_addr, brev(n_loaded));
                n_loaded++;
                if (n_loaded == N) begin
                    loading   = 1'b0;
                    last_load = cyc;
                end
            end

            if (bf_issue) begin
                if (issue_idx >= NB) begin
                    chk("bf_extra_issue", bf_issue, 0);
                end else begin
                    if (issue_idx == 0)
                        chk("first_issue_gap", cyc - last_load, 1);
                    else if (issue_idx % (N / 2) == 0)
                        chk("drain_gap", cyc - last_issue - 1, BL);
                    else
                        chk("issue_gap", cyc - last_issue - 1, 0);
                    chk("bf_addr_a", bf_addr_a, ref_a[issue_idx]);
                    chk("bf_addr_b", bf_addr_b, ref_b[issue_idx]);
                    chk("tw_idx", tw_idx, ref_tw[issue_idx]);
                    w.due = cyc + BL; w.a = ref_a[issue_idx]; w.b = ref_b[issue_idx];
                    wbq.push_back(w);
                    last_issue = cyc;
                    issue_idx++;
                    if (issue_idx == NB) us = cyc + BL + 1;
                end
            end

            exp_wb = (wbq.size() > 0) && (wbq[0].due == cyc);
            chk("wb_en", wb_en, exp_wb);
            if (exp_wb) begin
                w = wbq.pop_front();
                chk("wb_addr_a", wb_addr_a, w.a);
                chk("wb_addr_b", wb_addr_b, w.b);
            end

            exp_rd = (us >= 0) && (cyc >= us) && (cyc < us + N);
            chk("rd_en", rd_en, exp_rd);
            if (exp_rd) chk("rd_addr", rd_addr, cyc - us);
            chk("out_valid", out_valid, (us >= 0) && (cyc >= us + RL) && (cyc < us + RL + N));
            chk("out_last", out_last, (us >= 0) && (cyc == us + RL + N - 1));

            exp_done = (last_load >= 0) && (cyc == last_load + TOTAL);
            chk("done", done, exp_done);
            if (exp_done) fin = 1'b1;

            if (rst_mid && issue_idx == N / 2 + 2) begin
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (fin) break;
        end

        if (aborted) begin
            rst = 1'b0; start_data = 1'b0; in_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(negedge clk);
            chk("rst_mid_outputs", all_out, 0);
            for (int i = 0; i < BL + 3; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("rst_late_wb_en", wb_en, 0);
                chk("rst_late_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
            end
            @(posedge clk); #1;
        end else begin
            chk("timeout_done", fin, 1);
            chk("bf_count", issue_idx, NB);
            chk("wb_pending", wbq.size(), 0);
            start_data = 1'b0; in_valid = 1'b0;
            @(negedge clk);
            chk("after_done_busy", busy, 0);
            chk("after_done_pulse", done, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; start_data = 1'b0; inverse = 1'b0; in_valid = 1'b0;
        for (int s = 0; s < AW; s++) begin
            for (int b = 0; b < N / 2; b++) begin
                int half, pos, grp;
                half = 2 ** s;
                pos  = b % half;
                grp  = b / half;
                ref_a[s*N/2 + b]  = grp * 2 * half + pos;
                ref_b[s*N/2 + b]  = grp * 2 * half + pos + half;
                ref_tw[s*N/2 + b] = pos * (N / (2 * half));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs", all_out, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_fft(1'b0, 1'b0, 1'b0, 1'b0);
        run_fft(1'b1, 1'b0, 1'b0, 1'b0);
        run_fft(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
        run_fft(1'b1, 1'b1, 1'b0, 1'b1);
        run_fft(1'b1, 1'b1, 1'b1, 1'b0);
        run_fft(1'b0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
